// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN (adds a trailing checksum word).
package boot_loader_pkg;

  typedef enum logic [2:0] {
    HEADER,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the boot loader.
// The loader uses the slave modport; the byte source / memory side uses master.
interface imem_boot_loader_if;
  import boot_loader_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_boot_loader_assembler.sv
// Packs accepted bytes big-endian into 32-bit words. The completed word is
// presented combinationally during the 4th byte's handshake cycle, together
// with a one-cycle word_valid_o pulse, so the consumer can register it on that edge.
module byte_to_word_assembler
  import boot_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        byte_i,
  input  logic              accept_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  // Only the first three bytes need storing; the fourth comes straight from byte_i.
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-9:0] shift_q, shift_d;

  // Next-state: shift in each accepted byte and advance the byte counter.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (accept_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[WORD_W-17:0], byte_i};
    end
  end

  // Byte counter and shift register, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = accept_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a big-endian program image (word count N, N words, optional checksum)
// into instruction memory and releases the processor once the image is in.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN -- running XOR of the N words,
// checked against one trailing word before the processor is released.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 8,
  parameter logic [WORD_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  imem_boot_loader_if.slave     bus,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [WORD_W-1:0] DEPTH = 1 << ADDR_WIDTH;

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] n_q, n_d;
  logic [ADDR_WIDTH:0] idx_q, idx_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                accept;
  logic [WORD_W-1:0]   word;
  logic                word_valid;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [WORD_W-1:0]   csum_q, csum_d;
`endif

  assign accept = bus.in_valid & bus.in_ready;

  byte_to_word_assembler u_asm (
    .clock        (clock),
    .reset_n      (reset_n),
    .byte_i       (bus.in_data),
    .accept_i     (accept),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Next-state and write-port logic; the write strobe is registered, so a word
  // lands in memory the cycle after its 4th byte. The end-of-image decision is
  // taken in that write cycle, once the index has caught up with N.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      HEADER: begin
        if (word_valid) begin
          if (word == '0) begin
            state_d = DONE;
          end else if (word > DEPTH) begin
            state_d = ERROR;
          end else begin
            n_d     = word[ADDR_WIDTH:0];
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_valid) begin
          we_d    = 1'b1;
          wdata_d = word;
          addr_d  = BASE_ADDR + {{(WORD_W-ADDR_WIDTH-3){1'b0}}, idx_q, 2'b00};
          idx_d   = idx_q + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d  = csum_q ^ word;
`endif
        end
        if (we_q && (idx_q == n_q)) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      CHECK: begin
        if (word_valid) begin
          state_d = (word == csum_q) ? DONE : ERROR;
        end
      end
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // State, counters and write-port registers; reset aborts any load in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HEADER;
      n_q     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  // Running XOR of the instruction words (header excluded).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // in_ready is gated by reset_n so every output reads 0 while reset is held.
  assign bus.in_ready   = reset_n && (state_q inside {HEADER, LOAD, CHECK});
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_run        = (state_q == DONE);
  assign load_error     = (state_q == ERROR);
  assign words_loaded   = idx_q;

endmodule
